// File: rtl/uart_core.sv
// Register-mapped 8N1 UART: transmit holding register plus shifter on TxD,
// 16x-oversampled receiver on RxD, with polled status flags.
module uart_core #(
  parameter int BAUD_DIV = 27
) (
  input  logic       SysClk,
  input  logic       Reset,
  input  logic [1:0] Addr,
  input  logic [7:0] WrData,
  output logic [7:0] RdData,
  input  logic       CS_N,
  input  logic       RD_N,
  input  logic       WR_N,
  output logic       TxD,
  input  logic       RxD
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(BAUD_DIV - 1);

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic [CW-1:0] div_q, div_d;
  logic          tick;

  logic [1:0] tx_state_q, tx_state_d;
  logic [7:0] thr_q, thr_d;
  logic       thr_full_q, thr_full_d;
  logic [7:0] tsh_q, tsh_d;
  logic [3:0] tx_tcnt_q, tx_tcnt_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic       txd_q, txd_d;
  logic       tx_load;

  logic       rx_meta_q, rxs_q;
  logic [1:0] rx_state_q, rx_state_d;
  logic [3:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rsh_q, rsh_d;
  logic [7:0] rbr_q, rbr_d;
  logic       rdy_q, rdy_d;
  logic       ovr_q, ovr_d;
  logic       frm_q, frm_d;

  logic wr_thr, rd_ev, tx_empty;

  assign tick     = (div_q == DIV_LAST);
  assign div_d    = tick ? '0 : div_q + CW'(1);
  assign wr_thr   = !CS_N && !WR_N && (Addr == 2'b00);
  assign rd_ev    = !CS_N && !RD_N && WR_N;
  assign tx_empty = !thr_full_q && (tx_state_q == TX_IDLE);
  assign TxD      = txd_q;

  always_comb begin
    tx_state_d = tx_state_q;
    thr_d      = thr_q;
    thr_full_d = thr_full_q;
    tsh_d      = tsh_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bit_d   = tx_bit_q;
    txd_d      = txd_q;
    tx_load    = 1'b0;
    if (tx_state_q != TX_IDLE && tick) tx_tcnt_d = tx_tcnt_q + 4'd1;
    case (tx_state_q)
      TX_IDLE:  if (thr_full_q) tx_load = 1'b1;
      TX_START: if (tick && tx_tcnt_q == 4'd15) begin
        tx_state_d = TX_DATA;
        txd_d      = tsh_q[0];
        tx_bit_d   = 3'd0;
      end
      TX_DATA:  if (tick && tx_tcnt_q == 4'd15) begin
        if (tx_bit_q == 3'd7) begin
          tx_state_d = TX_STOP;
          txd_d      = 1'b1;
        end else begin
          tsh_d    = {1'b0, tsh_q[7:1]};
          txd_d    = tsh_q[1];
          tx_bit_d = tx_bit_q + 3'd1;
        end
      end
      TX_STOP:  if (tick && tx_tcnt_q == 4'd15) begin
        if (thr_full_q) tx_load = 1'b1;
        else tx_state_d = TX_IDLE;
      end
      default:  tx_state_d = TX_IDLE;
    endcase
    // Loading empties THR, so it can never coincide with an accepted write
    if (tx_load) begin
      tsh_d      = thr_q;
      thr_full_d = 1'b0;
      txd_d      = 1'b0;
      tx_state_d = TX_START;
      tx_tcnt_d  = 4'd0;
    end
    if (wr_thr && !thr_full_q) begin
      thr_d      = WrData;
      thr_full_d = 1'b1;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rsh_d      = rsh_q;
    rbr_d      = rbr_q;
    rdy_d      = rdy_q;
    ovr_d      = ovr_q;
    frm_d      = frm_q;
    if (rd_ev && Addr == 2'b00) rdy_d = 1'b0;
    if (rd_ev && Addr == 2'b01) begin
      ovr_d = 1'b0;
      frm_d = 1'b0;
    end
    if (tick) begin
      case (rx_state_q)
        RX_IDLE:  if (!rxs_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = 4'd0;
        end
        RX_START: if (rx_cnt_q == 4'd7) begin
          rx_cnt_d   = 4'd0;
          rx_bit_d   = 3'd0;
          rx_state_d = rxs_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 4'd1;
        end
        RX_DATA: begin
          rx_cnt_d = rx_cnt_q + 4'd1;
          if (rx_cnt_q == 4'd15) begin
            rsh_d    = {rxs_q, rsh_q[7:1]};
            rx_bit_d = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          end
        end
        RX_STOP: begin
          rx_cnt_d = rx_cnt_q + 4'd1;
          // Completion is applied after read-clears so its flags win
          if (rx_cnt_q == 4'd15) begin
            rbr_d      = rsh_q;
            if (!rxs_q) frm_d = 1'b1;
            if (rdy_q) ovr_d = 1'b1;
            rdy_d      = 1'b1;
            rx_state_d = RX_IDLE;
          end
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    RdData = 8'h00;
    if (!CS_N && !RD_N) begin
      case (Addr)
        2'b00:   RdData = rbr_q;
        2'b01:   RdData = {3'b000, !thr_full_q, tx_empty, frm_q, ovr_q, rdy_q};
        default: RdData = 8'h00;
      endcase
    end
  end

  always_ff @(posedge SysClk) begin
    if (!Reset) begin
      div_q      <= '0;
      tx_state_q <= TX_IDLE;
      thr_full_q <= 1'b0;
      tx_tcnt_q  <= 4'd0;
      tx_bit_q   <= 3'd0;
      txd_q      <= 1'b1;
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= 4'd0;
      rx_bit_q   <= 3'd0;
      rbr_q      <= 8'h00;
      rdy_q      <= 1'b0;
      ovr_q      <= 1'b0;
      frm_q      <= 1'b0;
    end else begin
      div_q      <= div_d;
      tx_state_q <= tx_state_d;
      thr_full_q <= thr_full_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bit_q   <= tx_bit_d;
      txd_q      <= txd_d;
      rx_meta_q  <= RxD;
      rxs_q      <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rbr_q      <= rbr_d;
      rdy_q      <= rdy_d;
      ovr_q      <= ovr_d;
      frm_q      <= frm_d;
    end
  end

  // Shift/holding data is qualified by the control state, so it needs no reset
  always_ff @(posedge SysClk) begin
    thr_q <= thr_d;
    tsh_q <= tsh_d;
    rsh_q <= rsh_d;
  end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Register-mapped UART peripheral that sits directly downstream of the polling character generator on the SysClk-domain peripheral bus (Addr / CS_N / RD_N / WR_N).
- Serialises bytes written to its transmit holding register onto TxD and deserialises RxD into a receive buffer.
- Reports both through a status register. The bus master polls status bit 3 (transmitter fully empty) before each write.
- Frame format fixed at 8N1, LSB first.

Parameters:
- BAUD_DIV, 27: SysClk cycles per oversample tick (50 MHz / (115200*16)). One bit = 16 ticks. Legal range >= 1.

Ports:
- SysClk  in  1  system clock
- Reset  in  1  synchronous, active-low reset
- Addr  in  2  register select
- WrData  in  8  write data from bus master (master's DataOut)
- RdData  out  8  read data to bus master (master's DataIn)
- CS_N  in  1  chip select, active low
- RD_N  in  1  read strobe, active low
- WR_N  in  1  write strobe, active low
- TxD  out  1  serial transmit, idle high
- RxD  in  1  serial receive, asynchronous

Behaviour:
- Reset: Reset is synchronous and active-low on clock SysClk. On reset:
  - TxD=1; THR empty; shift register empty; Tx FSM=TX_IDLE; Rx FSM=RX_IDLE.
  - RBR=0x00; RxReady=0; Overrun=0; Framing=0; tick counter=0; RxD synchroniser flops=1.
  - Reset mid-frame aborts both directions; TxD=1 from the next cycle.
- Register map (read):
  - Addr 00: RBR.
  - Addr 01: status = {3'b000, THREmpty[4], TxEmpty[3], Framing[2], Overrun[1], RxReady[0]}. TxEmpty = THR empty AND Tx FSM in TX_IDLE.
  - Addr 10/11: 0x00.
- Register map (write):
  - Addr 00: THR.
  - All other addresses are ignored.
- RdData timing:
  - Combinational. Equals the selected register while CS_N=0 and RD_N=0; 0x00 otherwise.
  - Read is valid in the same cycle the strobes are low.
- Read side effects (applied on each rising edge with CS_N=0, RD_N=0, WR_N=1):
  - Addr 00 clears RxReady.
  - Addr 01 clears Overrun and Framing.
  - A same-edge receive completion wins: its flags are set.
- Write (edge with CS_N=0, WR_N=0, Addr=00):
  - If THR is empty, load WrData into THR and set THREmpty=0.
  - If THR is full, the write is dropped with no flag.
  - WR_N and RD_N both low: write only, no read side effect.
- Tick generator: free-running counter 0..BAUD_DIV-1; tick is a one-cycle pulse when the counter wraps.
- Tx FSM: TX_IDLE -> TX_START -> TX_DATA (8 bits) -> TX_STOP -> TX_IDLE.
  - TX_IDLE with THR full: on the next edge, load the shift register from THR, set THR empty, drive TxD=0, enter TX_START, clear the 4-bit tick count.
  - Each state holds its TxD value for 16 ticks. The start bit may run up to 1 tick short because ticks are not realigned.
  - TX_DATA shifts LSB first.
  - TX_STOP drives 1. After 16 ticks it goes to TX_IDLE, or straight to TX_START if THR is full (back-to-back frames, no idle gap).
- Rx path: RxD passes through a 2-flop synchroniser (rxs). Rx FSM advances on ticks only.
  - RX_IDLE: rxs=0 -> RX_START, count=0.
  - RX_START: at count 7, rxs=0 -> RX_DATA with count=0; rxs=1 -> RX_IDLE (glitch rejected).
  - RX_DATA: sample at count 15, shift in LSB first; after the 8th sample -> RX_STOP.
  - RX_STOP: at count 15, load RBR. Framing is set if rxs=0. Overrun is set if RxReady was already 1 (RBR is overwritten). RxReady=1, then -> RX_IDLE.
  - Latency from the stop-bit midpoint to RxReady is 1 cycle.

Test Plan:
- Reset, BAUD_DIV=2 (bit = 32 cycles), read Addr 01 -> RdData=0x18, TxD=1, read Addr 00 -> 0x00.
- Write 0x41 to Addr 00:
  - Status bit3=0 within 2 cycles.
  - TxD emits 0, 1,0,0,0,0,0,1,0, 1; each bit 32 cycles, start bit 30-32 cycles.
  - Status returns to 0x18 after the stop bit.
- Write 0x42, then 0x43 immediately after THR empties, then 0x44 while THR is full:
  - 0x42 and 0x43 are sent back-to-back with no idle.
  - 0x44 never appears on TxD.
- Drive RxD frame 0x5A at 32 cycles/bit:
  - Status bit0=1.
  - Read Addr 00 -> 0x5A; next status read -> bit0=0.
- Receive 0x11 then 0x22 without reading RBR -> status=0x1B (Overrun=1), RBR=0x22. Next frame 0x33 with stop bit 0 -> Framing=1. Status read clears bits 1-2.
- 8-cycle low glitch on RxD -> no RxReady. Reset asserted mid-Tx-frame -> TxD=1 the next cycle, status=0x18.
